// File: rtl/cpu_bus_bridge_if.sv
// CPU strobe bus plus downstream valid/ready request/response channels.
// The slave modport is the bridge's view; the master modport is the environment's view.
interface cpu_bus_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_BYTES = 4
);
    logic                    IO;
    logic                    MEM;
    logic                    RD;
    logic                    WR;
    logic [ADDR_WIDTH-1:0]   A;
    logic [7:0]              D;
    logic                    cpu_ready;
    logic [7:0]              cpu_rdata;

    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic                    req_write;
    logic [8*DATA_BYTES-1:0] req_wdata;
    logic [DATA_BYTES-1:0]   req_wstrb;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [8*DATA_BYTES-1:0] rsp_rdata;

    modport slave (
        input  IO, MEM, RD, WR, A, D, req_ready, rsp_valid, rsp_rdata,
        output cpu_ready, cpu_rdata, req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready
    );

    modport master (
        output IO, MEM, RD, WR, A, D, req_ready, rsp_valid, rsp_rdata,
        input  cpu_ready, cpu_rdata, req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready
    );
endinterface

// File: rtl/cpu_bus_bridge.sv
// Bridges one 8-bit CPU strobe cycle at a time onto a 32-bit valid/ready request port,
// holding the CPU in wait state until the response, an unmapped decode or a timeout.
module cpu_bus_bridge #(
    parameter int unsigned                   ADDR_WIDTH     = 20,
    parameter int unsigned                   DATA_BYTES     = 4,
    parameter int unsigned                   NUM_WIN        = 2,
    parameter logic [NUM_WIN-1:0]            WIN_IO         = 2'b10,
    parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_BASE       = {20'h00000, 20'h80000},
    parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_MASK       = {20'hFFFF0, 20'h80000},
    parameter logic [NUM_WIN*32-1:0]         WIN_TGT        = {32'h4060_0000, 32'h8000_0000},
    parameter int unsigned                   TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_bus_bridge_if.slave  bus,
    input  logic             stat_clr,
    output logic             stat_unmapped,
    output logic             stat_timeout
);
    localparam int unsigned LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned DW     = 8 * DATA_BYTES;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_q;
    logic                cpu_ready_q;
    logic [7:0]          cpu_rdata_q;
    logic                req_valid_q;
    logic [31:0]         req_addr_q;
    logic                req_write_q;
    logic [DW-1:0]       req_wdata_q;
    logic [DATA_BYTES-1:0] req_wstrb_q;
    logic                rsp_ready_q;
    logic                stat_unmapped_q;
    logic                stat_timeout_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LANE_W-1:0]   lane_q;
    logic                abort_q;

    logic [3:0]          op;
    logic                op_legal;
    logic                hit_d;
    logic [31:0]         addr_d;
    logic [LANE_W-1:0]   lane_d;
    logic [7:0]          rsp_byte;

    assign op       = {bus.IO, bus.MEM, bus.RD, bus.WR};
    assign op_legal = (op == 4'b1010) || (op == 4'b0110) || (op == 4'b1001) || (op == 4'b0101);
    assign rsp_byte = 8'(bus.rsp_rdata >> {lane_q, 3'b000});

    // Window decode of the live bus cycle; the first (lowest-index) hit is kept.
    always_comb begin
        hit_d  = 1'b0;
        addr_d = '0;
        for (int unsigned i = 0; i < NUM_WIN; i++) begin
            if (!hit_d && (WIN_IO[i] == bus.IO) &&
                ((bus.A & WIN_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == WIN_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_d  = 1'b1;
                addr_d = WIN_TGT[i*32 +: 32] | 32'(bus.A & ~WIN_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]);
            end
        end
        lane_d = LANE_W'(addr_d & 32'(DATA_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cpu_ready_q     <= 1'b0;
            cpu_rdata_q     <= 8'h00;
            req_valid_q     <= 1'b0;
            req_addr_q      <= '0;
            req_write_q     <= 1'b0;
            req_wdata_q     <= '0;
            req_wstrb_q     <= '0;
            rsp_ready_q     <= 1'b0;
            stat_unmapped_q <= 1'b0;
            stat_timeout_q  <= 1'b0;
            cnt_q           <= '0;
            lane_q          <= '0;
            abort_q         <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (stat_clr) begin
                stat_unmapped_q <= 1'b0;
                stat_timeout_q  <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (op_legal) begin
                        abort_q <= 1'b0;
                        if (hit_d) begin
                            state_q     <= S_ISSUE;
                            req_valid_q <= 1'b1;
                            req_addr_q  <= addr_d;
                            req_write_q <= bus.WR;
                            req_wdata_q <= {DATA_BYTES{bus.D}};
                            req_wstrb_q <= bus.WR ? (DATA_BYTES'(1) << lane_d) : '0;
                            lane_q      <= lane_d;
                        end else begin
                            state_q         <= S_HOLD;
                            cpu_ready_q     <= 1'b1;
                            cpu_rdata_q     <= 8'hFF;
                            stat_unmapped_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!op_legal) abort_q <= 1'b1;
                    if (bus.req_ready) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                S_WAIT: begin
                    if (!op_legal) abort_q <= 1'b1;
                    if (bus.rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        if (abort_q || !op_legal) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q     <= S_HOLD;
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= req_write_q ? 8'h00 : rsp_byte;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q        <= S_DRAIN;
                        cnt_q          <= '0;
                        stat_timeout_q <= 1'b1;
                        cpu_rdata_q    <= 8'hFF;
                        cpu_ready_q    <= !abort_q && op_legal;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Once the CPU has ended its cycle, ready stays low until the late response is gone.
                    if (bus.rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (cpu_ready_q && op_legal) begin
                            state_q <= S_HOLD;
                        end else begin
                            state_q     <= S_IDLE;
                            cpu_ready_q <= 1'b0;
                        end
                    end else if (!op_legal) begin
                        cpu_ready_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!op_legal) begin
                        state_q     <= S_IDLE;
                        cpu_ready_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = req_addr_q;
    assign bus.req_write = req_write_q;
    assign bus.req_wdata = req_wdata_q;
    assign bus.req_wstrb = req_wstrb_q;
    assign bus.rsp_ready = rsp_ready_q;
    assign stat_unmapped = stat_unmapped_q;
    assign stat_timeout  = stat_timeout_q;
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench for cpu_bus_bridge: directed scenarios plus randomized accesses
// checked against a table-driven decode model.
module tb_cpu_bus_bridge;
    localparam int unsigned AW = 20;
    localparam int unsigned DB = 4;
    localparam int          TO = 1024;

    // Window table as listed for the default configuration (index 0 first).
    localparam bit          W_IO   [2] = '{1'b0, 1'b1};
    localparam logic [19:0] W_BASE [2] = '{20'h80000, 20'h00000};
    localparam logic [19:0] W_MASK [2] = '{20'h80000, 20'hFFFF0};
    localparam logic [31:0] W_TGT  [2] = '{32'h8000_0000, 32'h4060_0000};

    logic clk = 1'b0;
    logic rst_n;
    logic stat_clr;
    logic stat_unmapped;
    logic stat_timeout;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cpu_bus_bridge_if #(.ADDR_WIDTH(AW), .DATA_BYTES(DB)) bus ();

    cpu_bus_bridge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .stat_clr      (stat_clr),
        .stat_unmapped (stat_unmapped),
        .stat_timeout  (stat_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit act, input bit io, input bit wr);
        bus.IO  = act & io;
        bus.MEM = act & ~io;
        bus.RD  = act & ~wr;
        bus.WR  = act & wr;
    endtask

    function automatic void model_decode(input bit io, input logic [19:0] a,
                                         output bit hit, output logic [31:0] addr);
        hit  = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (!hit && W_IO[i] == io && (a & W_MASK[i]) == W_BASE[i]) begin
                hit  = 1'b1;
                addr = W_TGT[i] | {12'h000, a & ~W_MASK[i]};
            end
        end
    endfunction

    // Plays CPU and downstream for one access; edge 1 is the edge that samples the op.
    task automatic cpu_access(input bit io, input bit wr, input logic [19:0] a, input logic [7:0] d,
                              input int req_dly, input int rsp_dly, input logic [31:0] rdata,
                              input bit abort,
                              output bit saw_req, output logic [31:0] o_addr, output bit o_write,
                              output logic [31:0] o_wdata, output logic [3:0] o_wstrb,
                              output bit stable, output int hs_edge, output int ready_edge,
                              output logic [7:0] o_rdata, output bit dropped);
        int wait_req = 0;
        int wait_rsp = 0;
        int rsp_edge = -1;
        bit hs_done  = 1'b0;
        bit rsp_done = 1'b0;
        saw_req = 1'b0; o_addr = '0; o_write = 1'b0; o_wdata = '0; o_wstrb = '0;
        stable = 1'b1; hs_edge = -1; ready_edge = -1; o_rdata = '0; dropped = 1'b0;
        bus.A = a;
        bus.D = d;
        set_op(1'b1, io, wr);
        for (int c = 1; c <= 3000; c++) begin
            tick();
            bus.req_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            if (bus.cpu_ready && ready_edge < 0) begin
                ready_edge = c;
                o_rdata    = bus.cpu_rdata;
            end
            if (ready_edge > 0) break;
            if (bus.req_valid && !hs_done) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    o_addr = bus.req_addr; o_write = bus.req_write;
                    o_wdata = bus.req_wdata; o_wstrb = bus.req_wstrb;
                end else if (bus.req_addr !== o_addr || bus.req_write !== o_write ||
                             bus.req_wdata !== o_wdata || bus.req_wstrb !== o_wstrb) begin
                    stable = 1'b0;
                end
                if (wait_req >= req_dly) begin
                    bus.req_ready = 1'b1;
                    hs_done = 1'b1;
                    hs_edge = c + 1;
                end
                wait_req++;
            end else if (hs_done && !rsp_done && bus.rsp_ready) begin
                if (rsp_dly >= 0 && wait_rsp >= rsp_dly) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = rdata;
                    rsp_done = 1'b1;
                    rsp_edge = c + 1;
                end
                wait_rsp++;
            end
            if (abort && hs_done && c >= hs_edge) set_op(1'b0, 1'b0, 1'b0);
            if (abort && rsp_done && c >= rsp_edge + 3) break;
        end
        if (!abort && ready_edge > 0) begin
            set_op(1'b0, 1'b0, 1'b0);
            tick();
            dropped = !bus.cpu_ready;
        end
        set_op(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", bus.cpu_ready); end
        n_tests++; if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 00", bus.cpu_rdata); end
        n_tests++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
        n_tests++; if ({bus.req_addr, bus.req_write, bus.req_wdata, bus.req_wstrb} !== 69'h0) begin
            n_fail++; $display("FAIL reset_req_fields: got %h/%b/%h/%b want zeros", bus.req_addr, bus.req_write, bus.req_wdata, bus.req_wstrb); end
        n_tests++; if (bus.rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b want 0", bus.rsp_ready); end
        n_tests++; if ({stat_unmapped, stat_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_stats: got %b%b want 00", stat_unmapped, stat_timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mem_read();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        cpu_access(1'b0, 1'b0, 20'h80123, 8'h00, 0, 0, 32'h44332211, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (sr !== 1'b1) begin n_fail++; $display("FAIL memrd_req_seen: got %b want 1", sr); end
        n_tests++; if (ad !== 32'h8000_0123) begin n_fail++; $display("FAIL memrd_addr: got %h want 80000123", ad); end
        n_tests++; if ({wrt, ws} !== 5'b0_0000) begin n_fail++; $display("FAIL memrd_write_wstrb: got %b/%b want 0/0000", wrt, ws); end
        n_tests++; if (re !== 3) begin n_fail++; $display("FAIL memrd_latency: got %0d want 3", re); end
        n_tests++; if (rd !== 8'h44) begin n_fail++; $display("FAIL memrd_rdata: got %h want 44", rd); end
        n_tests++; if (dr !== 1'b1) begin n_fail++; $display("FAIL memrd_ready_drop: got %b want 1", dr); end
    endtask

    task automatic test_io_write();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        cpu_access(1'b1, 1'b1, 20'h00001, 8'h5A, 5, 1, 32'hDEADBEEF, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (ad !== 32'h4060_0001) begin n_fail++; $display("FAIL iowr_addr: got %h want 40600001", ad); end
        n_tests++; if (wrt !== 1'b1) begin n_fail++; $display("FAIL iowr_write: got %b want 1", wrt); end
        n_tests++; if (ws !== 4'b0010) begin n_fail++; $display("FAIL iowr_wstrb: got %b want 0010", ws); end
        n_tests++; if (wd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL iowr_wdata: got %h want 5a5a5a5a", wd); end
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL iowr_stable: got %b want 1", st); end
        n_tests++; if (he !== 7) begin n_fail++; $display("FAIL iowr_hs_edge: got %0d want 7", he); end
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL iowr_rdata: got %h want 00", rd); end
    endtask

    task automatic test_unmapped();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        cpu_access(1'b0, 1'b0, 20'h00100, 8'h00, 0, 0, 32'h0, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (sr !== 1'b0) begin n_fail++; $display("FAIL unmap_no_req: got %b want 0", sr); end
        n_tests++; if (re !== 1) begin n_fail++; $display("FAIL unmap_latency: got %0d want 1", re); end
        n_tests++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL unmap_rdata: got %h want ff", rd); end
        n_tests++; if (stat_unmapped !== 1'b1) begin n_fail++; $display("FAIL unmap_stat_set: got %b want 1", stat_unmapped); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_tests++; if (stat_unmapped !== 1'b0) begin n_fail++; $display("FAIL unmap_stat_clr: got %b want 0", stat_unmapped); end
    endtask

    task automatic test_timeout();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        cpu_access(1'b1, 1'b0, 20'h00002, 8'h00, 0, -1, 32'h0, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (re - he !== TO) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", re - he, TO); end
        n_tests++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL tmo_rdata: got %h want ff", rd); end
        n_tests++; if (stat_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_stat: got %b want 1", stat_timeout); end
        n_tests++; if (dr !== 1'b1) begin n_fail++; $display("FAIL tmo_ready_drop: got %b want 1", dr); end
        n_tests++; if (bus.rsp_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_drain_rsp_ready: got %b want 1", bus.rsp_ready); end
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = 32'hCAFEF00D;
        tick();
        bus.rsp_valid = 1'b0;
        n_tests++; if (bus.rsp_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_drained: got %b want 0", bus.rsp_ready); end
        cpu_access(1'b1, 1'b0, 20'h00002, 8'h00, 1, 2, 32'h11223344, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (sr !== 1'b1 || ad !== 32'h4060_0002) begin n_fail++; $display("FAIL tmo_next_req: got %b/%h want 1/40600002", sr, ad); end
        n_tests++; if (rd !== 8'h22) begin n_fail++; $display("FAIL tmo_next_rdata: got %h want 22", rd); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_tests++; if (stat_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_stat_clr: got %b want 0", stat_timeout); end
    endtask

    task automatic test_abort();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        cpu_access(1'b0, 1'b0, 20'h80004, 8'h00, 1, 2, 32'h01020304, 1'b1, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (sr !== 1'b1) begin n_fail++; $display("FAIL abort_req_issued: got %b want 1", sr); end
        n_tests++; if (re !== -1) begin n_fail++; $display("FAIL abort_no_ready: got edge %0d want none", re); end
        n_tests++; if ({bus.rsp_ready, bus.cpu_ready} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got %b want 00", {bus.rsp_ready, bus.cpu_ready}); end
        cpu_access(1'b0, 1'b0, 20'h80006, 8'h00, 0, 0, 32'hA1B2C3D4, 1'b0, sr, ad, wrt, wd, ws, st, he, re, rd, dr);
        n_tests++; if (re !== 3 || rd !== 8'hB2) begin n_fail++; $display("FAIL abort_next: got edge %0d data %h want 3/b2", re, rd); end
    endtask

    task automatic test_reset_issue();
        set_op(1'b1, 1'b0, 1'b0);
        bus.A = 20'h80010;
        bus.req_ready = 1'b0;
        tick();
        n_tests++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL rstiss_valid_before: got %b want 1", bus.req_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL rstiss_valid_async: got %b want 0", bus.req_valid); end
        n_tests++; if ({bus.req_addr, bus.cpu_ready, bus.rsp_ready} !== 34'h0) begin
            n_fail++; $display("FAIL rstiss_outputs: got %h/%b/%b want zeros", bus.req_addr, bus.cpu_ready, bus.rsp_ready); end
        set_op(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL rstiss_after_release: got %b want 0", bus.req_valid); end
    endtask

    task automatic test_random();
        bit sr, wrt, st, dr; logic [31:0] ad, wd; logic [3:0] ws; int he, re; logic [7:0] rd;
        bit io, wr, hit; logic [19:0] a; logic [7:0] d; logic [31:0] rdata, eaddr;
        logic [1:0] lane; logic [7:0] erd; logic [3:0] ews;
        for (int n = 0; n < 40; n++) begin
            io = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 20'($urandom);
            if (io && $urandom_range(0, 1) == 1) a = a & 20'h0000F;
            else if (!io && $urandom_range(0, 3) != 0) a[19] = 1'b1;
            d     = 8'($urandom);
            rdata = $urandom;
            model_decode(io, a, hit, eaddr);
            lane = eaddr[1:0];
            erd  = !hit ? 8'hFF : (wr ? 8'h00 : 8'(rdata >> (8 * lane)));
            ews  = wr ? (4'b0001 << lane) : 4'b0000;
            cpu_access(io, wr, a, d, $urandom_range(0, 3), $urandom_range(0, 3), rdata, 1'b0,
                       sr, ad, wrt, wd, ws, st, he, re, rd, dr);
            n_tests++; if (sr !== hit) begin n_fail++; $display("FAIL rnd%0d_hit: a=%h io=%b got %b want %b", n, a, io, sr, hit); end
            if (hit) begin
                n_tests++; if ({ad, wrt, wd, ws} !== {eaddr, wr, {4{d}}, ews}) begin
                    n_fail++; $display("FAIL rnd%0d_req: got %h/%b/%h/%b want %h/%b/%h/%b", n, ad, wrt, wd, ws, eaddr, wr, {4{d}}, ews); end
                n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_stable: got %b want 1", n, st); end
            end
            n_tests++; if (rd !== erd || dr !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_cpu: got %h/%b want %h/1", n, rd, dr, erd); end
            n_tests++; if (stat_unmapped !== !hit) begin n_fail++; $display("FAIL rnd%0d_stat: got %b want %b", n, stat_unmapped, !hit); end
            stat_clr = 1'b1;
            tick();
            stat_clr = 1'b0;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        stat_clr      = 1'b0;
        bus.A         = '0;
        bus.D         = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        set_op(1'b0, 1'b0, 1'b0);
        test_reset();
        test_mem_read();
        test_io_write();
        test_unmapped();
        test_timeout();
        test_abort();
        test_reset_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Sequential bridge between the 8-bit CPU bus (IO/MEM/RD/WR strobes, byte data) and a 32-bit-addressed valid/ready request/response port. It decodes each CPU bus cycle against a parametrised window table, issues a single downstream request, and holds the CPU in wait state until the response arrives. Unmapped accesses and response timeouts complete locally. It replaces static address translation in front of the AXI master, adding wait-state handshaking, configurable data width, timeout recovery and error status.

## Interface
Parameters:
- ADDR_WIDTH, 20, CPU address width (8..32).
- DATA_BYTES, 4, downstream data width in bytes (power of two, 1..8).
- NUM_WIN, 2, number of decode windows (1..16).
- WIN_IO, 2'b10, bit i=1: window i matches IO cycles; 0: MEM cycles.
- WIN_BASE, {20'h00000, 20'h80000}, packed NUM_WIN*ADDR_WIDTH; window i at bits [i*ADDR_WIDTH +: ADDR_WIDTH] (win0 = 0x80000, win1 = 0x00000).
- WIN_MASK, {20'hFFFF0, 20'h80000}, packed; bits set are compared.
- WIN_TGT, {32'h4060_0000, 32'h8000_0000}, packed NUM_WIN*32; downstream base.
- TIMEOUT_CYCLES, 1024, max WAIT_RSP cycles (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- IO, MEM, RD, WR  in  1 each  CPU bus strobes.
- A  in  ADDR_WIDTH  CPU address.
- D  in  8  CPU write data.
- cpu_ready  out  1  1 = cycle complete, CPU may end it.
- cpu_rdata  out  8  read data, valid while cpu_ready.
- req_valid / req_ready  out / in  1  request handshake.
- req_addr  out  32  byte address.
- req_write  out  1  1 = write.
- req_wdata  out  8*DATA_BYTES  D replicated across all lanes.
- req_wstrb  out  DATA_BYTES  one-hot byte strobe (0 on reads).
- rsp_valid / rsp_ready  in / out  1  response handshake.
- rsp_rdata  in  8*DATA_BYTES  read data.
- stat_clr  in  1  clears sticky status.
- stat_unmapped, stat_timeout  out  1  sticky error flags.

## Operation
- Legal ops: {IO,MEM,RD,WR} = 1010 IO read, 0110 MEM read, 1001 IO write, 0101 MEM write; any other value is idle.
- Decode: window i hits when space matches WIN_IO[i] and (A & MASK_i) == BASE_i; lowest index wins. req_addr = TGT_i | zero-extended (A & ~MASK_i). Lane = req_addr[log2(DATA_BYTES)-1:0]; wstrb = 1<<lane; cpu_rdata = rsp_rdata[lane*8 +: 8].
- States: IDLE, ISSUE, WAIT_RSP, HOLD, DRAIN.
- IDLE: on legal op, latch A, D, op and decode result. Hit -> ISSUE; miss -> HOLD with rdata 0xFF, set stat_unmapped.
- ISSUE: req_valid=1 with stable fields until req_ready; then WAIT_RSP. No timeout in ISSUE.
- WAIT_RSP: rsp_ready=1; on rsp_valid capture the lane byte (writes: 0x00) -> HOLD. Count cycles; at TIMEOUT_CYCLES without rsp -> DRAIN with rdata 0xFF, set stat_timeout, cpu_ready=1.
- DRAIN: rsp_ready=1, cpu_ready=1; on rsp_valid (discarded) -> HOLD, or -> IDLE if strobes already idle. A new CPU op is not accepted until the response is drained.
- HOLD: cpu_ready=1; when op becomes idle -> IDLE. A change to a different legal op without idle in between is ignored.
- CPU abort (op goes idle in ISSUE/WAIT_RSP): transaction completes downstream, result discarded, -> IDLE after response.
- stat_clr clears both flags; simultaneous set and clear: set wins.

## Timing
- Reset: state IDLE, cpu_ready=0, cpu_rdata=0x00, req_valid=0, req_addr=0, req_write=0, req_wdata=0, req_wstrb=0, rsp_ready=0, stats=0, counter=0. Reset mid-transaction abandons it immediately.
- All outputs registered.
- Op sampled at edge N -> req_valid high from N+1.
- Handshake at edge M -> rsp_ready high from M+1.
- rsp_valid at edge K -> cpu_ready and cpu_rdata valid from K+1.
- Best-case read latency: op to cpu_ready = 3 cycles. Unmapped: cpu_ready from N+1.
- cpu_ready drops the cycle after op idle is sampled.

## Test plan
- MEM read A=0x80123, rsp_rdata=0x44332211 with immediate ready -> req_addr=0x8000_0123, wstrb=0; cpu_rdata=0x44 three cycles after op.
- IO write A=0x0001, D=0x5A, req_ready delayed 5 cycles -> req_addr=0x4060_0001, wstrb=4'b0010, wdata=0x5A5A5A5A held stable until handshake.
- MEM read A=0x00100 -> no req_valid; cpu_ready next cycle, cpu_rdata=0xFF, stat_unmapped=1; stat_clr clears it.
- IO read A=0x02 with no response -> cpu_ready=1 and rdata=0xFF after 1024 WAIT_RSP cycles, stat_timeout=1; late rsp is consumed in DRAIN and the next op issues normally.
- Strobes drop during WAIT_RSP -> response accepted, cpu_ready never asserted, returns to IDLE.
- rst_n low during ISSUE -> req_valid=0 asynchronously, all outputs at reset values.
